program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Boot-time sequencer that writes a host-supplied program into the 16-byte RAM through the input/MAR register, then releases the CPU.
- Sits between the chip pins and the shared 8-bit bus.
- While loading, it owns the bus, the MAR/data load strobes and the RAM write strobe, and it holds the control block in reset.
- After loading it drives nothing and only asserts cpu_hold low.

Parameters:
- RAM_BYTES, 16, number of RAM locations to fill; the load terminates after this many bytes.
- ADDR_W, 4, address width; RAM_BYTES must be at most 2^ADDR_W.
- SYNC_STAGES, 2, flop stages on each asynchronous pin input (minimum 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- load_mode  input  1  pin: high at/after reset requests program load; asynchronous.
- host_valid  input  1  pin: host byte strobe; each rising edge delivers one byte; asynchronous.
- host_end  input  1  pin: high ends the load early; asynchronous.
- host_data  input  8  pin: program byte; host holds it stable while host_valid is high.
- host_ready  output  1  high only when the loader will accept the next byte.
- bus_oe  output  1  high: the loader drives bus_out onto the shared bus.
- bus_out  output  8  value driven onto the bus when bus_oe is high.
- n_load_addr  output  1  active-low MAR address load, ANDed into nLma by the top level.
- n_load_data  output  1  active-low MAR data load, ANDed into nLmd.
- n_ram_we  output  1  active-low RAM write strobe.
- cpu_hold  output  1  high holds the control block and PC in reset.
- load_done  output  1  high in DONE.
- byte_count  output  ADDR_W+1  number of bytes written so far.

Behaviour:
- Reset (asynchronous, immediate, including mid-write):
  - state=IDLE; host_ready=0; bus_oe=0; bus_out=0.
  - n_load_addr=1; n_load_data=1; n_ram_we=1.
  - cpu_hold=1; load_done=0; byte_count=0; sync flops=0.
- Synchronisation and edge detection:
  - load_mode, host_valid and host_end each pass through SYNC_STAGES flops.
  - A valid edge means synced host_valid=1 and the previous synced value=0.
  - An end edge is detected the same way on host_end.
  - host_data is captured into an internal register on the cycle the valid edge is seen.
- States:
  - IDLE: wait SYNC_STAGES+1 cycles (counter) for the synchronisers to settle. Then go to WAIT_BYTE if synced load_mode=1, otherwise go to RUN.
  - WAIT_BYTE: host_ready=1.
    - A valid edge captures data and goes to LD_ADDR.
    - Otherwise an end edge goes to DONE.
    - If both happen in the same cycle, the byte is taken and the end edge is dropped; the host must re-strobe host_end.
  - LD_ADDR (1 cycle): bus_oe=1; bus_out={zeros, addr}; n_load_addr=0.
  - LD_DATA (1 cycle): bus_oe=1; bus_out=captured byte; n_load_data=0.
  - WRITE (1 cycle): bus_oe=0; n_ram_we=0; byte_count increments on exit.
    - If byte_count+1==RAM_BYTES, go to DONE.
    - Otherwise addr increments and the state goes to WAIT_BYTE.
  - DONE: load_done=1; cpu_hold=1. Go to RUN when synced load_mode=0.
  - RUN: cpu_hold=0; all strobes inactive; bus_oe=0; host_ready=0. RUN is terminal until rst; load_mode is ignored.
- Timing:
  - All outputs are registered and decoded from state.
  - At most one of n_load_addr, n_load_data and n_ram_we is low in any cycle.
  - bus_oe is never high in WAIT_BYTE, DONE or RUN.
- Latency: the first strobe (n_load_addr low) appears SYNC_STAGES+1 cycles after a host_valid rise. One byte takes 3 cycles once the valid edge is seen.
- Host rules:
  - A host_valid edge outside WAIT_BYTE is ignored; the byte is lost, and byte_count and addr are unchanged.
  - host_valid held high produces a single byte.
- Address and byte count:
  - addr never wraps; the load stops at RAM_BYTES.
  - Locations not written keep their previous RAM contents.
  - byte_count saturates at RAM_BYTES.

Test Plan:
- load_mode=0 through reset, then rst deasserted -> cpu_hold falls after SYNC_STAGES+1+1 cycles; bus_oe, strobes and host_ready stay inactive thereafter.
- load_mode=1; 16 bytes 0x10..0x1F strobed with host_valid -> each byte gives n_load_addr low (bus_out=index), then n_load_data low (bus_out=byte), then n_ram_we low. Then load_done=1 and byte_count=16; RAM reads back 0x10..0x1F. After load_mode drops, cpu_hold=0.
- load_mode=1; 3 bytes 0xA1,0xB2,0xC3 then a host_end pulse -> DONE with byte_count=3; only addresses 0..2 are written; locations 3..15 are unchanged.
- host_valid re-pulsed during LD_DATA -> the pulse is ignored; byte_count advances by exactly 1; host_ready=0 until WAIT_BYTE.
- rst asserted during WRITE of byte 5 -> n_ram_we, bus_oe and n_load_* go inactive immediately; cpu_hold=1; byte_count=0; after release with load_mode=1 the loader restarts at address 0.
- host_valid and host_end rise together in WAIT_BYTE -> the byte is written and the loader returns to WAIT_BYTE, not DONE.

Source files
------------

// File: rtl/program_loader.sv
// Boot-time program loader: streams host bytes into RAM through the MAR path,
// then releases the CPU by dropping cpu_hold.
module program_loader #(
  parameter int RAM_BYTES   = 16,
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_mode,
  input  logic              host_valid,
  input  logic              host_end,
  input  logic [7:0]        host_data,
  output logic              host_ready,
  output logic              bus_oe,
  output logic [7:0]        bus_out,
  output logic              n_load_addr,
  output logic              n_load_data,
  output logic              n_ram_we,
  output logic              cpu_hold,
  output logic              load_done,
  output logic [ADDR_W:0]   byte_count,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_BYTE = 3'd1,
    LD_ADDR   = 3'd2,
    LD_DATA   = 3'd3,
    WRITE     = 3'd4,
    DONE      = 3'd5,
    RUN       = 3'd6
  } state_t;

  localparam int                CNT_W  = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0]  SETTLE = CNT_W'(SYNC_STAGES + 1);
  localparam logic [ADDR_W:0]   LAST   = (ADDR_W + 1)'(RAM_BYTES);

  state_t                   state;
  logic [CNT_W-1:0]         settle_cnt;
  logic [ADDR_W-1:0]        addr;
  logic [7:0]               data_q;
  logic [SYNC_STAGES-1:0]   mode_sync;
  logic [SYNC_STAGES-1:0]   valid_sync;
  logic [SYNC_STAGES-1:0]   end_sync;
  logic                     valid_prev;
  logic                     end_prev;
  logic                     mode_s;
  logic                     valid_s;
  logic                     end_s;
  logic                     valid_rise;
  logic                     end_rise;

  assign mode_s     = mode_sync[SYNC_STAGES-1];
  assign valid_s    = valid_sync[SYNC_STAGES-1];
  assign end_s      = end_sync[SYNC_STAGES-1];
  assign valid_rise = valid_s & ~valid_prev;
  assign end_rise   = end_s & ~end_prev;
  assign dbg_state  = state;

  // Host handshake: host_ready is high only in WAIT_BYTE; a synchronised rising
  // edge of host_valid while host_ready is high transfers host_data, and any
  // edge seen while host_ready is low is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      settle_cnt  <= '0;
      addr        <= '0;
      data_q      <= '0;
      mode_sync   <= '0;
      valid_sync  <= '0;
      end_sync    <= '0;
      valid_prev  <= 1'b0;
      end_prev    <= 1'b0;
      host_ready  <= 1'b0;
      bus_oe      <= 1'b0;
      bus_out     <= '0;
      n_load_addr <= 1'b1;
      n_load_data <= 1'b1;
      n_ram_we    <= 1'b1;
      cpu_hold    <= 1'b1;
      load_done   <= 1'b0;
      byte_count  <= '0;
    end else begin
      mode_sync   <= {mode_sync[SYNC_STAGES-2:0], load_mode};
      valid_sync  <= {valid_sync[SYNC_STAGES-2:0], host_valid};
      end_sync    <= {end_sync[SYNC_STAGES-2:0], host_end};
      valid_prev  <= valid_s;
      end_prev    <= end_s;
      // Outputs are decoded from the state being entered, so they line up with it.
      host_ready  <= 1'b0;
      bus_oe      <= 1'b0;
      bus_out     <= '0;
      n_load_addr <= 1'b1;
      n_load_data <= 1'b1;
      n_ram_we    <= 1'b1;
      case (state)
        IDLE: begin
          if (settle_cnt == SETTLE) begin
            if (mode_s) begin
              state      <= WAIT_BYTE;
              host_ready <= 1'b1;
            end else begin
              state    <= RUN;
              cpu_hold <= 1'b0;
            end
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        WAIT_BYTE: begin
          // A byte wins over a simultaneous end edge; the end edge is consumed.
          if (valid_rise) begin
            data_q      <= host_data;
            state       <= LD_ADDR;
            bus_oe      <= 1'b1;
            bus_out     <= 8'(addr);
            n_load_addr <= 1'b0;
          end else if (end_rise) begin
            state     <= DONE;
            load_done <= 1'b1;
          end else begin
            host_ready <= 1'b1;
          end
        end
        LD_ADDR: begin
          state       <= LD_DATA;
          bus_oe      <= 1'b1;
          bus_out     <= data_q;
          n_load_data <= 1'b0;
        end
        LD_DATA: begin
          state    <= WRITE;
          n_ram_we <= 1'b0;
        end
        WRITE: begin
          byte_count <= byte_count + 1'b1;
          if ((byte_count + 1'b1) == LAST) begin
            state     <= DONE;
            load_done <= 1'b1;
          end else begin
            addr       <= addr + 1'b1;
            state      <= WAIT_BYTE;
            host_ready <= 1'b1;
          end
        end
        DONE: begin
          if (!mode_s) begin
            state     <= RUN;
            load_done <= 1'b0;
            cpu_hold  <= 1'b0;
          end
        end
        RUN: begin
          state <= RUN;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: models the MAR/RAM path on the bus and
// checks strobe sequencing, early end, ignored strobes and mid-write reset.
module tb_program_loader;

  localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_DONE = 3'd5, S_RUN = 3'd6;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_mode;
  logic       host_valid;
  logic       host_end;
  logic [7:0] host_data;
  logic       host_ready;
  logic       bus_oe;
  logic [7:0] bus_out;
  logic       n_load_addr;
  logic       n_load_data;
  logic       n_ram_we;
  logic       cpu_hold;
  logic       load_done;
  logic [4:0] byte_count;
  logic [2:0] dbg_state;

  int errors = 0;
  int checks = 0;

  // External MAR and RAM, filled with 0xEE while ram_fill is high.
  logic [7:0] ram [16];
  logic [3:0] mar;
  logic [7:0] mdr;
  logic       ram_fill;

  program_loader dut (
    .clk(clk), .rst(rst), .load_mode(load_mode), .host_valid(host_valid),
    .host_end(host_end), .host_data(host_data), .host_ready(host_ready),
    .bus_oe(bus_oe), .bus_out(bus_out), .n_load_addr(n_load_addr),
    .n_load_data(n_load_data), .n_ram_we(n_ram_we), .cpu_hold(cpu_hold),
    .load_done(load_done), .byte_count(byte_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_fill) begin
      for (int i = 0; i < 16; i++) ram[i] <= 8'hEE;
    end else begin
      if (!n_load_addr) mar <= bus_out[3:0];
      if (!n_load_data) mdr <= bus_out;
      if (!n_ram_we) ram[mar] <= mdr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ram_fill = 1'b1;
    tick();
    ram_fill = 1'b0;
    rst = 1'b0;
  endtask

  // One host byte: valid edge seen after 2 sync edges, LD_ADDR on the third.
  task automatic send_byte(input logic [3:0] idx, input logic [7:0] d);
    host_data = d;
    host_valid = 1'b1;
    repeat (3) tick();
    chk("ld_addr_strobe", {7'd0, n_load_addr}, 8'd0);
    chk("ld_addr_bus", bus_out, {4'd0, idx});
    chk("ld_addr_oe", {7'd0, bus_oe}, 8'd1);
    chk("ld_addr_ready", {7'd0, host_ready}, 8'd0);
    tick();
    host_valid = 1'b0;
    chk("ld_data_strobe", {7'd0, n_load_data}, 8'd0);
    chk("ld_data_bus", bus_out, d);
    tick();
    chk("write_strobe", {7'd0, n_ram_we}, 8'd0);
    chk("write_oe", {7'd0, bus_oe}, 8'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1; load_mode = 1'b0; host_valid = 1'b0; host_end = 1'b0;
    host_data = 8'h00; ram_fill = 1'b1;
    repeat (2) tick();
    ram_fill = 1'b0;

    // Reset values
    chk("rst_ready", {7'd0, host_ready}, 8'd0);
    chk("rst_oe", {7'd0, bus_oe}, 8'd0);
    chk("rst_bus", bus_out, 8'h00);
    chk("rst_strobes", {5'd0, n_load_addr, n_load_data, n_ram_we}, 8'h07);
    chk("rst_hold", {7'd0, cpu_hold}, 8'd1);
    chk("rst_done", {7'd0, load_done}, 8'd0);
    chk("rst_count", {3'd0, byte_count}, 8'd0);
    chk("rst_state", {5'd0, dbg_state}, {5'd0, S_IDLE});

    // No load: cpu_hold drops on the fourth edge after release
    rst = 1'b0;
    repeat (3) tick();
    chk("run_hold_early", {7'd0, cpu_hold}, 8'd1);
    tick();
    chk("run_hold", {7'd0, cpu_hold}, 8'd0);
    chk("run_state", {5'd0, dbg_state}, {5'd0, S_RUN});
    host_valid = 1'b1;
    load_mode = 1'b1;
    repeat (5) tick();
    chk("run_oe", {7'd0, bus_oe}, 8'd0);
    chk("run_ready", {7'd0, host_ready}, 8'd0);
    chk("run_strobes", {5'd0, n_load_addr, n_load_data, n_ram_we}, 8'h07);
    chk("run_state_kept", {5'd0, dbg_state}, {5'd0, S_RUN});
    host_valid = 1'b0;

    // Full 16-byte load
    do_reset();
    repeat (4) tick();
    chk("full_wait", {5'd0, dbg_state}, {5'd0, S_WAIT});
    chk("full_ready", {7'd0, host_ready}, 8'd1);
    for (int i = 0; i < 16; i++) send_byte(4'(i), 8'h10 + 8'(i));
    chk("full_done", {7'd0, load_done}, 8'd1);
    chk("full_count", {3'd0, byte_count}, 8'd16);
    chk("full_hold", {7'd0, cpu_hold}, 8'd1);
    chk("full_ready_done", {7'd0, host_ready}, 8'd0);
    chk("full_state", {5'd0, dbg_state}, {5'd0, S_DONE});
    for (int i = 0; i < 16; i++) chk("full_ram", ram[i], 8'h10 + 8'(i));
    load_mode = 1'b0;
    repeat (3) tick();
    chk("full_release", {7'd0, cpu_hold}, 8'd0);
    chk("full_done_clr", {7'd0, load_done}, 8'd0);

    // Early end after 3 bytes
    load_mode = 1'b1;
    do_reset();
    repeat (4) tick();
    send_byte(4'd0, 8'hA1);
    send_byte(4'd1, 8'hB2);
    send_byte(4'd2, 8'hC3);
    host_end = 1'b1;
    repeat (3) tick();
    host_end = 1'b0;
    chk("end_state", {5'd0, dbg_state}, {5'd0, S_DONE});
    chk("end_done", {7'd0, load_done}, 8'd1);
    chk("end_count", {3'd0, byte_count}, 8'd3);
    chk("end_ram0", ram[0], 8'hA1);
    chk("end_ram1", ram[1], 8'hB2);
    chk("end_ram2", ram[2], 8'hC3);
    for (int i = 3; i < 16; i++) chk("end_ram_keep", ram[i], 8'hEE);

    // Second valid edge lands in LD_DATA and is dropped
    do_reset();
    repeat (4) tick();
    host_data = 8'h5A;
    host_valid = 1'b1;
    tick();
    host_valid = 1'b0;
    tick();
    host_valid = 1'b1;
    tick();
    chk("dup_ld_addr", {7'd0, n_load_addr}, 8'd0);
    tick();
    chk("dup_ld_data", {7'd0, n_load_data}, 8'd0);
    chk("dup_ready", {7'd0, host_ready}, 8'd0);
    tick();
    chk("dup_write", {7'd0, n_ram_we}, 8'd0);
    tick();
    chk("dup_wait_ready", {7'd0, host_ready}, 8'd1);
    chk("dup_count", {3'd0, byte_count}, 8'd1);
    repeat (6) tick();
    chk("dup_count_held", {3'd0, byte_count}, 8'd1);
    chk("dup_state_held", {5'd0, dbg_state}, {5'd0, S_WAIT});
    chk("dup_ram0", ram[0], 8'h5A);
    host_valid = 1'b0;
    repeat (3) tick();

    // Reset during WRITE of the fifth byte
    do_reset();
    repeat (4) tick();
    for (int i = 0; i < 4; i++) send_byte(4'(i), 8'h30 + 8'(i));
    host_data = 8'h34;
    host_valid = 1'b1;
    repeat (5) tick();
    chk("mid_write", {7'd0, n_ram_we}, 8'd0);
    rst = 1'b1;
    #1;
    chk("mid_we", {7'd0, n_ram_we}, 8'd1);
    chk("mid_oe", {7'd0, bus_oe}, 8'd0);
    chk("mid_ld", {6'd0, n_load_addr, n_load_data}, 8'h03);
    chk("mid_hold", {7'd0, cpu_hold}, 8'd1);
    chk("mid_count", {3'd0, byte_count}, 8'd0);
    host_valid = 1'b0;
    tick();
    chk("mid_ram4", ram[4], 8'hEE);
    chk("mid_ram3", ram[3], 8'h33);
    rst = 1'b0;
    repeat (4) tick();
    send_byte(4'd0, 8'h77);
    chk("mid_restart_count", {3'd0, byte_count}, 8'd1);
    chk("mid_restart_ram0", ram[0], 8'h77);

    // host_valid and host_end together: byte wins, stays in WAIT_BYTE
    host_end = 1'b1;
    send_byte(4'd1, 8'h88);
    chk("both_state", {5'd0, dbg_state}, {5'd0, S_WAIT});
    chk("both_done", {7'd0, load_done}, 8'd0);
    chk("both_count", {3'd0, byte_count}, 8'd2);
    chk("both_ram1", ram[1], 8'h88);
    host_end = 1'b0;
    repeat (3) tick();
    host_end = 1'b1;
    repeat (3) tick();
    host_end = 1'b0;
    chk("both_restrobe", {5'd0, dbg_state}, {5'd0, S_DONE});
    chk("both_restrobe_done", {7'd0, load_done}, 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
